// File: rtl/fp_pkg.sv
// Shared types and helpers for the floating-point add/subtract pipeline:
// operand classes, the exception flag bundle and canonical special encodings.
package fp_pkg;

    typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fp_class_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Subnormals classify as ZERO: they are flushed before the datapath sees them.
    function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic man_zero, input logic man_msb);
        if (exp_zero)  return ZERO;
        if (!exp_ones) return NORM;
        if (man_zero)  return INF;
        return man_msb ? QNAN : SNAN;
    endfunction

    // Positive infinity, right-aligned in 64 bits; callers truncate to their word width.
    function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
        return (64'd1 << (exp_w + man_w)) - (64'd1 << man_w);
    endfunction

    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return fp_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc #(
    parameter  int WIDTH = 27,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] d,
    output logic [CW-1:0]    cnt
);

    logic found;

    always_comb begin
        cnt   = CW'(WIDTH);
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && d[i]) begin
                cnt   = CW'(WIDTH - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_addsub.sv
// Five-stage IEEE-754-style adder/subtractor, round-to-nearest-even, flush-to-zero,
// one global stall enable shared by every stage.
module fp_addsub
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic                   op_sub,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [TAG_W-1:0]       tag_in,
    output logic [TAG_W-1:0]       tag_out,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int WM     = W - 1;
    localparam int FW     = MAN_W + 4;          // hidden + mantissa + guard/round/sticky
    localparam int SW     = EXP_W + 2;
    localparam int LZW    = $clog2(FW + 1);
    localparam int STAGES = 5;

    localparam logic [W-1:0]         QNAN_W = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [WM-1:0]        INF_M  = WM'(fp_inf(EXP_W, MAN_W));
    localparam logic signed [SW-1:0] EMAX   = SW'((1 << EXP_W) - 1);

    typedef struct packed {
        logic             sign;
        logic             zsign;
        logic             sp;
        logic [W-1:0]     sp_word;
        fp_flags_t        sp_flags;
        logic [TAG_W-1:0] tag;
    } side_t;

    logic              en;
    logic [STAGES:1]   vld_pipe;
    side_t             side_in;
    side_t             side_q [1:STAGES-1];

    assign en      = !out_vld || out_rdy;
    assign in_rdy  = en;
    assign out_vld = vld_pipe[STAGES];

    // S1: classify, flush subnormals, order operands so |x| >= |y|
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic [MAN_W:0]   fa, fb;
    logic             sa, sb, a_ge;
    fp_class_e        ca, cb;

    assign sa   = a[W-1];
    assign sb   = b[W-1] ^ op_sub;
    assign ea   = a[W-2:MAN_W];
    assign eb   = b[W-2:MAN_W];
    assign ma   = a[MAN_W-1:0];
    assign mb   = b[MAN_W-1:0];
    assign ca   = fp_classify(ea == '0, &ea, ma == '0, ma[MAN_W-1]);
    assign cb   = fp_classify(eb == '0, &eb, mb == '0, mb[MAN_W-1]);
    assign fa   = (ca == ZERO) ? '0 : {1'b1, ma};
    assign fb   = (cb == ZERO) ? '0 : {1'b1, mb};
    assign a_ge = {ea, fa} >= {eb, fb};

    always_comb begin
        side_in          = '0;
        side_in.sign     = a_ge ? sa : sb;
        side_in.zsign    = sa & sb;
        side_in.tag      = tag_in;
        if (ca == QNAN || ca == SNAN || cb == QNAN || cb == SNAN) begin
            side_in.sp               = 1'b1;
            side_in.sp_word          = QNAN_W;
            side_in.sp_flags.invalid = (ca == SNAN) || (cb == SNAN);
        end else if (ca == INF && cb == INF) begin
            side_in.sp               = 1'b1;
            side_in.sp_word          = (sa != sb) ? QNAN_W : {sa, INF_M};
            side_in.sp_flags.invalid = (sa != sb);
        end else if (ca == INF) begin
            side_in.sp      = 1'b1;
            side_in.sp_word = {sa, INF_M};
        end else if (cb == INF) begin
            side_in.sp      = 1'b1;
            side_in.sp_word = {sb, INF_M};
        end
    end

    logic [EXP_W-1:0] s1_ex, s1_diff;
    logic [MAN_W:0]   s1_mx, s1_my;
    logic             s1_sub;

    // S2: align y; everything shifted past the sticky position collapses into it
    logic [2*FW-1:0] al_wide;
    logic [FW-1:0]   al;

    assign al_wide = {s1_my, 3'b000, {FW{1'b0}}} >> s1_diff;

    always_comb begin
        if (int'(s1_diff) >= MAN_W + 3) al = {{(FW-1){1'b0}}, |s1_my};
        else                            al = {al_wide[2*FW-1:FW+1], al_wide[FW] | (|al_wide[FW-1:0])};
    end

    logic [MAN_W:0]   s2_mx;
    logic [FW-1:0]    s2_al;
    logic             s2_sub;
    logic [EXP_W-1:0] s2_ex;

    // S3: magnitude add/sub; x >= y so the difference never goes negative
    logic [FW:0] sum_c;
    assign sum_c = s2_sub ? {1'b0, s2_mx, 3'b000} - {1'b0, s2_al}
                          : {1'b0, s2_mx, 3'b000} + {1'b0, s2_al};

    logic [FW:0]      s3_sum;
    logic [EXP_W-1:0] s3_ex;

    // S4: normalise; the hidden bit after normalising is 0 only for a zero sum
    logic [LZW-1:0]         lz;
    logic [FW-1:0]          norm;
    logic signed [SW-1:0]   e_n;

    fp_lzc #(.WIDTH(FW)) u_lzc (.d(s3_sum[FW-1:0]), .cnt(lz));

    always_comb begin
        if (s3_sum[FW]) begin
            norm = {s3_sum[FW:2], s3_sum[1] | s3_sum[0]};
            e_n  = {2'b00, s3_ex} + SW'(1);
        end else begin
            norm = s3_sum[FW-1:0] << lz;
            e_n  = {2'b00, s3_ex} - SW'(lz);
        end
    end

    logic [FW-2:0]        s4_n;
    logic signed [SW-1:0] s4_e;
    logic                 s4_zero;

    // S5: round to nearest even, re-normalise on mantissa carry, pack
    logic                 rup, rc, inx;
    logic [MAN_W-1:0]     man_r;
    logic signed [SW-1:0] ef;
    logic [W-1:0]         r_word;
    fp_flags_t            r_flags;
    side_t                sd;

    assign sd           = side_q[STAGES-1];
    assign rup          = s4_n[2] & (s4_n[1] | s4_n[0] | s4_n[3]);
    assign {rc, man_r}  = {1'b0, s4_n[FW-2:3]} + {{MAN_W{1'b0}}, rup};
    assign ef           = rc ? s4_e + SW'(1) : s4_e;
    assign inx          = |s4_n[2:0];

    always_comb begin
        r_word          = {sd.sign, ef[EXP_W-1:0], man_r};
        r_flags         = '0;
        r_flags.inexact = inx;
        if (sd.sp) begin
            r_word  = sd.sp_word;
            r_flags = sd.sp_flags;
        end else if (s4_zero) begin
            r_word  = {sd.zsign, {WM{1'b0}}};
            r_flags = '0;
        end else if (ef <= 0) begin
            r_word            = {sd.sign, {WM{1'b0}}};
            r_flags.underflow = 1'b1;
            r_flags.inexact   = 1'b1;
        end else if (ef >= EMAX) begin
            r_word           = {sd.sign, INF_M};
            r_flags.overflow = 1'b1;
            r_flags.inexact  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_ex     <= a_ge ? ea : eb;
            s1_diff   <= a_ge ? ea - eb : eb - ea;
            s1_mx     <= a_ge ? fa : fb;
            s1_my     <= a_ge ? fb : fa;
            s1_sub    <= sa ^ sb;
            side_q[1] <= side_in;
            for (int i = 2; i < STAGES; i++) side_q[i] <= side_q[i-1];
            s2_mx     <= s1_mx;
            s2_al     <= al;
            s2_sub    <= s1_sub;
            s2_ex     <= s1_ex;
            s3_sum    <= sum_c;
            s3_ex     <= s2_ex;
            s4_n      <= norm[FW-2:0];
            s4_e      <= e_n;
            s4_zero   <= !norm[FW-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            result   <= '0;
            flags    <= '0;
            tag_out  <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_vld};
            result   <= r_word;
            flags    <= r_flags;
            tag_out  <= sd.tag;
        end
    end

endmodule

// File: tb/tb_fp_addsub.sv
// Directed bench for fp_addsub: scoreboard of expected results checked on every
// output transfer, plus latency, stall-hold and reset-flush checks.
module tb_fp_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic        op_sub = 1'b0;
    logic [31:0] a = '0, b = '0, result;
    logic [3:0]  tag_in = '0, tag_out, flags;
    logic        out_vld;
    logic        out_rdy = 1'b1;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic        have_prev = 1'b0;
    logic [39:0] prev;

    always #5 clk = ~clk;

    fp_addsub #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .op_sub(op_sub),
        .a(a), .b(b), .tag_in(tag_in), .tag_out(tag_out), .out_vld(out_vld),
        .out_rdy(out_rdy), .result(result), .flags(flags)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic sub,
                        input logic [3:0] t, input logic [31:0] er, input logic [3:0] ef);
        int n = 0;
        in_vld = 1'b1; a = xa; b = xb; op_sub = sub; tag_in = t;
        #1;
        while (!in_rdy && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n == 50) chk("accept_timeout", 64'(in_rdy), 64'd1);
        sb.push_back('{t, er, ef});
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk); n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    // Output monitor: every transfer pops the scoreboard; a stalled output must hold.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev) chk("hold", 64'({result, flags, tag_out}), 64'(prev));
            have_prev = 1'b0;
            if (out_vld && !out_rdy) begin
                have_prev = 1'b1;
                prev      = {result, flags, tag_out};
            end else if (out_vld) begin
                chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("tag", 64'(tag_out), 64'(e.tag));
                    chk("result", 64'(result), 64'(e.res));
                    chk("flags", 64'(flags), 64'(e.fl));
                end
            end
        end
    end

    logic [31:0] str_exp [8] = '{32'h40000000, 32'h40400000, 32'h40A00000, 32'h41100000,
                                 32'h41880000, 32'h42040000, 32'h42820000, 32'h43010000};

    initial begin
        int n;
        int seen;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_tag", 64'(tag_out), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        send(32'h3F800000, 32'h40000000, 1'b0, 4'd1, 32'h40400000, 4'b0000);
        n = 1;
        while (!out_vld && n < 20) begin
            @(negedge clk); n++;
        end
        chk("latency", 64'(n), 64'd5);
        drain();

        send(32'h3F800000, 32'h3F800000, 1'b1, 4'd0,  32'h00000000, 4'b0000);
        send(32'h80000000, 32'h80000000, 1'b0, 4'd1,  32'h80000000, 4'b0000);
        send(32'h80000000, 32'h00000000, 1'b1, 4'd2,  32'h80000000, 4'b0000);
        send(32'h7F800000, 32'hFF800000, 1'b0, 4'd3,  32'h7FC00000, 4'b1000);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd4,  32'h7F800000, 4'b0101);
        send(32'h3F800000, 32'h33800000, 1'b0, 4'd5,  32'h3F800000, 4'b0001);
        send(32'h3F800000, 32'h33800001, 1'b0, 4'd6,  32'h3F800001, 4'b0001);
        send(32'h40400000, 32'h3F800000, 1'b1, 4'd7,  32'h40000000, 4'b0000);
        send(32'h3F800000, 32'h40000000, 1'b1, 4'd8,  32'hBF800000, 4'b0000);
        send(32'h7FC00001, 32'h3F800000, 1'b0, 4'd9,  32'h7FC00000, 4'b0000);
        send(32'h7F800001, 32'h3F800000, 1'b0, 4'd10, 32'h7FC00000, 4'b1000);
        send(32'h7F800000, 32'h3F800000, 1'b0, 4'd11, 32'h7F800000, 4'b0000);
        send(32'h3F800000, 32'h7F800000, 1'b1, 4'd12, 32'hFF800000, 4'b0000);
        send(32'h00000001, 32'h00000001, 1'b0, 4'd13, 32'h00000000, 4'b0000);
        send(32'h00800001, 32'h00800000, 1'b1, 4'd14, 32'h00000000, 4'b0011);
        send(32'h80000001, 32'h3F800000, 1'b0, 4'd15, 32'h3F800000, 4'b0000);
        send(32'h3F7FFFFF, 32'h33000000, 1'b0, 4'd0,  32'h3F800000, 4'b0001);
        drain();

        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(32'h3F800000 + (32'(i) << 23), 32'h3F800000, 1'b0, 4'(i), str_exp[i], 4'b0000);
            end
            begin
                repeat (7) @(negedge clk);
                out_rdy = 1'b0;
                repeat (3) begin
                    #1;
                    chk("stall_in_rdy", 64'(in_rdy), 64'd0);
                    @(negedge clk);
                end
                out_rdy = 1'b1;
            end
        join
        drain();

        send(32'h3F800000, 32'h40000000, 1'b0, 4'd9,  32'h40400000, 4'b0000);
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd10, 32'h40400000, 4'b0000);
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd11, 32'h40400000, 4'b0000);
        rst = 1'b0;
        #1;
        chk("rst_flush_out_vld", 64'(out_vld), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (out_vld) seen++;
        end
        chk("stale_after_rst", 64'(seen), 64'd0);
        @(negedge clk);

        send(32'h3F800000, 32'h3F800000, 1'b0, 4'd5, 32'h40000000, 4'b0000);
        n = 1;
        while (!out_vld && n < 20) begin
            @(negedge clk); n++;
        end
        chk("latency_after_rst", 64'(n), 64'd5);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
